// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: one valid/ready source feeds four single-entry output channels.
// Define DEMUX_RR_EN to steer by an internal round-robin pointer instead of in_sel.
module demux_1to4_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]     acc_cnt
);

    logic [1:0] target;
    logic       accept;

`ifdef DEMUX_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] unused_sel;

    assign unused_sel = in_sel;
    assign target     = rr_ptr;

    // The pointer only moves on an accept, so a stalled channel is never skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (accept) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end
`else
    assign target = in_sel;
`endif

    // A full channel whose consumer drains it this cycle can take a new word with no bubble.
    assign in_ready = rst_n & (~out_valid[target] | out_ready[target]);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            acc_cnt   <= '0;
        end else begin
            if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            for (int i = 0; i < 4; i++) begin
                if (accept && (target == 2'(i))) begin
                    out_valid[i]                 <= 1'b1;
                    out_data[i*WIDTH +: WIDTH]   <= in_data;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed bench for demux_1to4_reg: accepted words go into a scoreboard queue and are
// checked against the channel they should land on one edge later.
module tb_demux_1to4_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [CNT_W-1:0]   acc_cnt;

    typedef struct packed {
        logic [1:0]       ch;
        logic [WIDTH-1:0] d;
    } sb_t;

    sb_t sb_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    demux_1to4_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .acc_cnt   (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan(input logic [1:0] ch);
        return out_data[ch*WIDTH +: WIDTH];
    endfunction

    // Drive one word; if it is expected to be taken, remember where it must land.
    task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] d,
                        input logic exp_rdy, input logic [1:0] exp_ch);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy) sb_q.push_back('{ch: exp_ch, d: d});
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Advance one edge and retire the word (if any) accepted on it.
    task automatic cycle();
        sb_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_valid", 32'(out_valid[e.ch]), 32'd1);
            chk("sb_data", 32'(chan(e.ch)), 32'(e.d));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
        #2;
        do_reset();

        // basic steering
        send(2'd2, 8'hA5, 1'b1, 2'd2); cycle();
        send(2'd0, 8'h3C, 1'b1, 2'd0); cycle();
        idle();
        chk("steer_valid", 32'(out_valid), 32'b0101);
        chk("steer_ch2", 32'(chan(2'd2)), 32'hA5);
        chk("steer_ch0", 32'(chan(2'd0)), 32'h3C);
        chk("steer_acc", 32'(acc_cnt), 32'd2);

        // asynchronous reset with words held, mid-cycle, input still presenting
        in_valid = 1'b1;
        #2;
        do_reset();

        // backpressure on channel 1
        send(2'd1, 8'h11, 1'b1, 2'd1); cycle();
        send(2'd1, 8'h22, 1'b0, 2'd1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_data", 32'(chan(2'd1)), 32'h11);
            chk("bp_hold_valid", 32'(out_valid[1]), 32'd1);
        end
        out_ready[1] = 1'b1;
        send(2'd1, 8'h22, 1'b1, 2'd1); cycle();
        idle();
        chk("bp_acc", 32'(acc_cnt), 32'd2);
        cycle();
        chk("bp_drained", 32'(out_valid[1]), 32'd0);
        chk("bp_data_kept", 32'(chan(2'd1)), 32'h22);
        out_ready = 4'b0000;

        // independence: channel 0 stalled does not block channel 3
        send(2'd0, 8'h55, 1'b1, 2'd0); cycle();
        send(2'd0, 8'h77, 1'b0, 2'd0);
        send(2'd3, 8'h66, 1'b1, 2'd3); cycle();
        idle();
        chk("ind_valid", 32'(out_valid), 32'b1001);
        chk("ind_ch0", 32'(chan(2'd0)), 32'h55);
        chk("ind_acc", 32'(acc_cnt), 32'd4);

        // ready on an empty channel has no effect
        out_ready[2] = 1'b1;
        cycle();
        chk("empty_ready", 32'(out_valid), 32'b1001);

        // streaming with counter wrap
        do_reset();
        out_ready = 4'hF;
        for (int k = 0; k < 18; k++) begin
            send(2'd3, 8'(k), 1'b1, 2'd3);
            cycle();
            if (k == 15) chk("wrap_zero", 32'(acc_cnt), 32'd0);
        end
        idle();
        chk("stream_last", 32'(chan(2'd3)), 32'h11);
        chk("stream_acc", 32'(acc_cnt), 32'd2);
        cycle();
        chk("stream_drained", 32'(out_valid), 32'd0);

`ifdef DEMUX_RR_EN
        do_reset();
        out_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            send(2'd0, 8'(k + 1), 1'b1, 2'(k));
            cycle();
        end
        idle();
        do_reset();
        out_ready = 4'b1011;
        send(2'd0, 8'hA0, 1'b1, 2'd0); cycle();
        send(2'd0, 8'hA1, 1'b1, 2'd1); cycle();
        send(2'd0, 8'hA2, 1'b1, 2'd2); cycle();
        send(2'd0, 8'hA3, 1'b1, 2'd3); cycle();
        send(2'd0, 8'hA4, 1'b1, 2'd0); cycle();
        send(2'd0, 8'hA5, 1'b1, 2'd1); cycle();
        send(2'd0, 8'hA6, 1'b0, 2'd2);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rr_stall_data", 32'(chan(2'd2)), 32'hA2);
        end
        out_ready[2] = 1'b1;
        send(2'd0, 8'hA6, 1'b1, 2'd2); cycle();
        idle();
        chk("rr_acc", 32'(acc_cnt), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
